audio_frame_sequencer: RTL

- Sequences the stereo reverb datapath between the audio controller's Avalon-ST channels and the reverb core.
- Collects one left and one right sample into a stereo frame, then starts the core with a one-cycle pulse and waits for its done pulse.
- Returns the processed pair to the audio controller's sink channels, and counts samples dropped while busy.
- Supports a bypass path that skips the core.

---
 rtl/audio_frame_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/audio_frame_sequencer.sv
// Stereo frame sequencer between the audio controller Avalon-ST channels and the reverb core.
// Optional core watchdog: define AUDIO_SEQ_TIMEOUT_EN to enable the WAIT timeout and timeout_cnt.
module audio_frame_sequencer #(
   parameter int DATA_W         = 24,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] left_in_data,
   input  logic              left_in_valid,
   output logic              left_in_ready,
   input  logic [DATA_W-1:0] right_in_data,
   input  logic              right_in_valid,
   output logic              right_in_ready,
   output logic [DATA_W-1:0] core_left_in,
   output logic [DATA_W-1:0] core_right_in,
   output logic              core_start,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_left_out,
   input  logic [DATA_W-1:0] core_right_out,
   output logic [DATA_W-1:0] left_out_data,
   output logic              left_out_valid,
   input  logic              left_out_ready,
   output logic [DATA_W-1:0] right_out_data,
   output logic              right_out_valid,
   input  logic              right_out_ready,
   input  logic              bypass,
   output logic              busy,
   output logic [CNT_W-1:0]  overrun_cnt,
   output logic [CNT_W-1:0]  timeout_cnt
);

   typedef enum logic [1:0] {COLLECT, START, WAIT, OUT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic             l_flag, r_flag, bypass_q;
   logic             l_xfer, r_xfer;
   logic [1:0]       drops;
   logic [CNT_W:0]   ovr_sum;
   logic [CNT_W-1:0] ovr_next;

   assign l_xfer = left_in_valid & left_in_ready;
   assign r_xfer = right_in_valid & right_in_ready;
   assign busy   = (state != COLLECT);

   // Only COLLECT accepts samples, and only into an empty channel slot.
   always_comb begin
      drops = 2'd0;
      if (state == COLLECT)
         drops = {1'b0, l_xfer & l_flag} + {1'b0, r_xfer & r_flag};
      else
         drops = {1'b0, l_xfer} + {1'b0, r_xfer};
      ovr_sum  = {1'b0, overrun_cnt} + (CNT_W+1)'(drops);
      ovr_next = ovr_sum[CNT_W] ? CNT_MAX : ovr_sum[CNT_W-1:0];
   end

`ifdef AUDIO_SEQ_TIMEOUT_EN
   localparam int WT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WT_W-1:0] TO_LAST = WT_W'(TIMEOUT_CYCLES - 1);
   logic [WT_W-1:0] wait_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT_CYCLES;
   assign timeout_cnt    = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= COLLECT;
         l_flag          <= 1'b0;
         r_flag          <= 1'b0;
         bypass_q        <= 1'b0;
         left_in_ready   <= 1'b0;
         right_in_ready  <= 1'b0;
         core_left_in    <= '0;
         core_right_in   <= '0;
         core_start      <= 1'b0;
         left_out_data   <= '0;
         right_out_data  <= '0;
         left_out_valid  <= 1'b0;
         right_out_valid <= 1'b0;
         overrun_cnt     <= '0;
`ifdef AUDIO_SEQ_TIMEOUT_EN
         wait_cnt        <= '0;
         timeout_cnt     <= '0;
`endif
      end else begin
         left_in_ready  <= 1'b1;
         right_in_ready <= 1'b1;
         overrun_cnt    <= ovr_next;
         case (state)
            COLLECT: begin
               if (l_xfer && !l_flag) begin
                  core_left_in <= left_in_data;
                  l_flag       <= 1'b1;
               end
               if (r_xfer && !r_flag) begin
                  core_right_in <= right_in_data;
                  r_flag        <= 1'b1;
               end
               // bypass is taken as the frame completes so core_start can be a registered pulse.
               if ((l_flag || l_xfer) && (r_flag || r_xfer)) begin
                  state      <= START;
                  bypass_q   <= bypass;
                  core_start <= !bypass;
               end
            end
            START: begin
               core_start <= 1'b0;
               l_flag     <= 1'b0;
               r_flag     <= 1'b0;
               if (bypass_q) begin
                  left_out_data   <= core_left_in;
                  right_out_data  <= core_right_in;
                  left_out_valid  <= 1'b1;
                  right_out_valid <= 1'b1;
                  state           <= OUT;
               end else begin
                  state <= WAIT;
`ifdef AUDIO_SEQ_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end
            end
            WAIT: begin
               if (core_done) begin
                  left_out_data   <= core_left_out;
                  right_out_data  <= core_right_out;
                  left_out_valid  <= 1'b1;
                  right_out_valid <= 1'b1;
                  state           <= OUT;
               end
`ifdef AUDIO_SEQ_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  left_out_data   <= '0;
                  right_out_data  <= '0;
                  left_out_valid  <= 1'b1;
                  right_out_valid <= 1'b1;
                  if (timeout_cnt != CNT_MAX)
                     timeout_cnt <= timeout_cnt + CNT_W'(1);
                  state <= OUT;
               end else begin
                  wait_cnt <= wait_cnt + WT_W'(1);
               end
`endif
            end
            OUT: begin
               if (left_out_valid && left_out_ready)
                  left_out_valid <= 1'b0;
               if (right_out_valid && right_out_ready)
                  right_out_valid <= 1'b0;
               if ((!left_out_valid || left_out_ready) && (!right_out_valid || right_out_ready))
                  state <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule
